// File: rtl/callret_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : callret_ctrl
// Description : Call/return sequencer in front of the return-address stack.
//               A CALL pushes the return address and then loads the target
//               into the PC. A RET pops the saved address and then loads it
//               into the PC. Every sequence takes 3 cycles and finishes with
//               a one-cycle oPCLoad pulse.
// Optional    : CALLRET_GUARD_EN adds overflow, underflow and conflict
//               detection with a sticky first-fault code. When the macro is
//               undefined, oFault and oFaultCode are tied to 0.
// Ports       : Clock, Reset (sync, active-high)
//               iCall, iRet, iReturnAddr, iTarget      - decoder requests
//               iStackPointer, iStackData              - from stack
//               oStackWrite, oStackRead, oStackData    - to stack
//               oBusy, oPCLoad, oPCValue               - to fetch unit
//               oFault, oFaultCode                     - guard status
// Revision    : 1.0 - initial release
// ============================================================================
module callret_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int SP_WIDTH   = 6,
    parameter int MEM_SIZE   = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCall,
    input  logic                  iRet,
    input  logic [DATA_WIDTH-1:0] iReturnAddr,
    input  logic [DATA_WIDTH-1:0] iTarget,
    input  logic [SP_WIDTH-1:0]   iStackPointer,
    input  logic [DATA_WIDTH-1:0] iStackData,
    output logic                  oStackWrite,
    output logic                  oStackRead,
    output logic [DATA_WIDTH-1:0] oStackData,
    output logic                  oBusy,
    output logic                  oPCLoad,
    output logic [DATA_WIDTH-1:0] oPCValue,
    output logic                  oFault,
    output logic [1:0]            oFaultCode
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PUSH = 2'd1;
    localparam logic [1:0] S_POP  = 2'd2;
    localparam logic [1:0] S_LOAD = 2'd3;

    localparam logic [1:0] C_FAULT_NONE      = 2'd0;
    localparam logic [1:0] C_FAULT_OVERFLOW  = 2'd1;
    localparam logic [1:0] C_FAULT_UNDERFLOW = 2'd2;
    localparam logic [1:0] C_FAULT_CONFLICT  = 2'd3;

    localparam logic [SP_WIDTH-1:0] C_SP_FULL  = SP_WIDTH'(MEM_SIZE - 1);
    localparam logic [SP_WIDTH-1:0] C_SP_EMPTY = '0;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_save;
    logic [DATA_WIDTH-1:0] w_save_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;

    // Blocking conditions on the request accepted in IDLE. Without the guard
    // they are constant 0, so the stack's own saturation/wrap applies.
    logic w_block_call;
    logic w_block_ret;

`ifdef CALLRET_GUARD_EN
    logic       r_fault;
    logic [1:0] r_fault_code;
    logic       w_fault_event;
    logic [1:0] w_fault_event_code;

    assign w_block_call = (iStackPointer == C_SP_FULL);
    assign w_block_ret  = (iStackPointer == C_SP_EMPTY);

    // Overflow outranks conflict: a blocked call never executes, so the
    // more severe condition is the one reported.
    always_comb begin
        w_fault_event      = 1'b0;
        w_fault_event_code = C_FAULT_NONE;
        if (r_state == S_IDLE) begin
            if (iCall && w_block_call) begin
                w_fault_event      = 1'b1;
                w_fault_event_code = C_FAULT_OVERFLOW;
            end else if (iCall && iRet) begin
                w_fault_event      = 1'b1;
                w_fault_event_code = C_FAULT_CONFLICT;
            end else if (!iCall && iRet && w_block_ret) begin
                w_fault_event      = 1'b1;
                w_fault_event_code = C_FAULT_UNDERFLOW;
            end
        end
    end

    // Only the first fault is recorded; later ones leave the code intact.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_fault      <= 1'b0;
            r_fault_code <= C_FAULT_NONE;
        end else if (w_fault_event && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_event_code;
        end
    end

    assign oFault     = r_fault;
    assign oFaultCode = r_fault_code;
`else
    logic w_unused_sp;

    assign w_block_call = 1'b0;
    assign w_block_ret  = 1'b0;
    assign w_unused_sp  = ^iStackPointer;
    assign oFault       = 1'b0;
    assign oFaultCode   = C_FAULT_NONE;
`endif

    // Next-state logic. A call takes priority over a simultaneous return.
    always_comb begin
        w_state_next = r_state;
        w_save_next  = r_save;
        w_pc_next    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (iCall) begin
                    if (!w_block_call) begin
                        w_save_next  = iReturnAddr;
                        w_pc_next    = iTarget;
                        w_state_next = S_PUSH;
                    end
                end else if (iRet) begin
                    if (!w_block_ret) begin
                        w_state_next = S_POP;
                    end
                end
            end
            S_PUSH: w_state_next = S_LOAD;
            S_POP: begin
                // Top-of-stack is valid while the read strobe is high.
                w_pc_next    = iStackData;
                w_state_next = S_LOAD;
            end
            S_LOAD: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_save  <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_save  <= w_save_next;
            r_pc    <= w_pc_next;
        end
    end

    // Moore outputs. POP is always followed by LOAD, so the read strobe is
    // guaranteed to drop for at least one cycle between consecutive pops.
    assign oStackWrite = (r_state == S_PUSH);
    assign oStackRead  = (r_state == S_POP);
    assign oStackData  = r_save;
    assign oPCLoad     = (r_state == S_LOAD);
    assign oPCValue    = r_pc;
    assign oBusy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_callret_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_callret_ctrl
// Description : Self-checking bench for callret_ctrl. Models the stack the
//               sequencer drives and keeps a reference queue of saved return
//               addresses plus the expected first-fault state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_callret_ctrl;

    localparam int DW   = 16;
    localparam int SW   = 6;
    localparam int MEMS = 64;
`ifdef CALLRET_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iCall = 1'b0;
    logic          iRet  = 1'b0;
    logic [DW-1:0] iReturnAddr = '0;
    logic [DW-1:0] iTarget     = '0;
    logic [SW-1:0] iStackPointer;
    logic [DW-1:0] iStackData;
    logic          oStackWrite;
    logic          oStackRead;
    logic [DW-1:0] oStackData;
    logic          oBusy;
    logic          oPCLoad;
    logic [DW-1:0] oPCValue;
    logic          oFault;
    logic [1:0]    oFaultCode;

    callret_ctrl #(.DATA_WIDTH(DW), .SP_WIDTH(SW), .MEM_SIZE(MEMS)) dut (
        .Clock(Clock), .Reset(Reset), .iCall(iCall), .iRet(iRet),
        .iReturnAddr(iReturnAddr), .iTarget(iTarget),
        .iStackPointer(iStackPointer), .iStackData(iStackData),
        .oStackWrite(oStackWrite), .oStackRead(oStackRead),
        .oStackData(oStackData), .oBusy(oBusy), .oPCLoad(oPCLoad),
        .oPCValue(oPCValue), .oFault(oFault), .oFaultCode(oFaultCode)
    );

    always #5 Clock = ~Clock;

    // Return-address stack environment: write at sp then increment, pop
    // decrements, top-of-stack is the entry just below the pointer.
    logic [DW-1:0] mem [MEMS];
    logic [SW-1:0] sp = '0;
    always @(posedge Clock) begin
        if (Reset) sp <= '0;
        else if (oStackWrite) begin
            mem[sp] <= oStackData;
            sp      <= sp + 1'b1;
        end else if (oStackRead) sp <= sp - 1'b1;
    end
    assign iStackPointer = sp;
    assign iStackData    = mem[sp - 1'b1];

    // Reference model
    logic [DW-1:0] ref_q [$];
    bit            exp_fault;
    int            exp_code;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic note_fault(input int code);
        if (GUARD && !exp_fault) begin
            exp_fault = 1'b1;
            exp_code  = code;
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1; iCall = 1'b0; iRet = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        ref_q.delete();
        exp_fault = 1'b0;
        exp_code  = 0;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_wr"},    oStackWrite, 0);
        check({tag, "_rd"},    oStackRead,  0);
        check({tag, "_busy"},  oBusy,       0);
        check({tag, "_load"},  oPCLoad,     0);
        check({tag, "_sdata"}, oStackData,  0);
        check({tag, "_pcval"}, oPCValue,    0);
        check({tag, "_fault"}, oFault,      0);
        check({tag, "_code"},  oFaultCode,  0);
    endtask

    // One request issued in IDLE; outcome predicted from the rules:
    // call wins over return, guard blocks a call at full / return at empty.
    task automatic seq(input bit c, input bit r, input logic [DW-1:0] ra, input logic [DW-1:0] tg);
        int            depth = ref_q.size();
        bit            do_call = c && !(GUARD && depth == MEMS - 1);
        bit            do_ret  = !c && r && !(GUARD && depth == 0);
        logic [DW-1:0] exp_pc;
        if (c && !do_call) note_fault(1);
        else if (c && r)   note_fault(3);
        else if (!c && r && !do_ret) note_fault(2);
        if (do_call) begin
            exp_pc = tg;
            ref_q.push_back(ra);
        end else if (do_ret) begin
            exp_pc = ref_q[$];
            ref_q.pop_back();
        end else exp_pc = '0;
        iCall = c; iRet = r; iReturnAddr = ra; iTarget = tg;
        @(posedge Clock); #1;
        // Requests during busy cycles must be dropped.
        if (do_call || do_ret) begin
            iCall = 1'($urandom); iRet = 1'($urandom);
            iReturnAddr = DW'($urandom); iTarget = DW'($urandom);
        end else begin
            iCall = 1'b0; iRet = 1'b0;
        end
        check("s1_wr",   oStackWrite, do_call);
        check("s1_rd",   oStackRead,  do_ret);
        check("s1_busy", oBusy,       do_call || do_ret);
        check("s1_load", oPCLoad,     0);
        if (do_call) check("s1_sdata", oStackData, ra);
        @(posedge Clock); #1;
        check("s2_load", oPCLoad,     do_call || do_ret);
        check("s2_wr",   oStackWrite, 0);
        check("s2_rd",   oStackRead,  0);
        check("s2_sp",   iStackPointer, ref_q.size());
        if (do_call || do_ret) check("s2_pcval", oPCValue, exp_pc);
        @(posedge Clock); #1;
        iCall = 1'b0; iRet = 1'b0;
        check("s3_busy",  oBusy,      0);
        check("s3_load",  oPCLoad,    0);
        check("s3_fault", oFault,     exp_fault);
        check("s3_code",  oFaultCode, exp_code);
    endtask

    initial begin
        apply_reset();
        check_all_idle("rst");

        // Basic call then return
        seq(1'b1, 1'b0, 16'h0011, 16'h0200);
        seq(1'b0, 1'b1, 16'h0000, 16'h0000);

        // Nested calls, LIFO returns
        seq(1'b1, 1'b0, 16'h000A, 16'h1000);
        seq(1'b1, 1'b0, 16'h000B, 16'h2000);
        seq(1'b1, 1'b0, 16'h000C, 16'h3000);
        seq(1'b0, 1'b1, 16'h0000, 16'h0000);
        seq(1'b0, 1'b1, 16'h0000, 16'h0000);
        seq(1'b0, 1'b1, 16'h0000, 16'h0000);

        // Conflict: call wins
        seq(1'b1, 1'b1, 16'h0033, 16'h0400);
        seq(1'b0, 1'b1, 16'h0000, 16'h0000);

`ifdef CALLRET_GUARD_EN
        check("conf_fault", oFault, 1);
        check("conf_code",  oFaultCode, 3);
        apply_reset();
        check_all_idle("rst2");
        // Underflow, then an overflow that must not replace the code
        seq(1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < MEMS - 1; i++) seq(1'b1, 1'b0, DW'(i + 16'h0100), DW'(i));
        seq(1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
        check("ovf_code", oFaultCode, 2);
        for (int i = 0; i < MEMS - 1; i++) seq(1'b0, 1'b1, 16'h0000, 16'h0000);
`endif

        // Randomised mix, staying inside the stack's legal range
        for (int i = 0; i < 40; i++) begin
            bit c = 1'($urandom);
            bit r = 1'($urandom);
            if (!c && !r) r = 1'b1;
            if (ref_q.size() == 0) c = 1'b1;
            if (ref_q.size() == MEMS - 1) begin c = 1'b0; r = 1'b1; end
            seq(c, r, DW'($urandom), DW'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            #1;
        end

        // Reset during PUSH aborts the call
        apply_reset();
        iCall = 1'b1; iReturnAddr = 16'h0055; iTarget = 16'h0666;
        @(posedge Clock); #1;
        iCall = 1'b0;
        check("abort_push", oStackWrite, 1);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        ref_q.delete();
        check_all_idle("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            check("abort_noload", oPCLoad, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/callret_ctrl.md
# callret_ctrl

Call/return sequencer that sits directly upstream of the hardware return-address stack. It turns decoder CALL/RET requests into single-cycle stack write/read strobes and a program-counter load. On a call it pushes the return address, then loads the target. On a return it pops the saved address, then loads it into the PC. Optional guard logic detects overflow, underflow and conflicting requests before the stack is touched.

## Interface
- DATA_WIDTH, 16, width of addresses and stack entries
- SP_WIDTH, 6, width of stack pointer seen from the stack
- MEM_SIZE, 64, stack depth in entries
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- iCall  in  1  call request, sampled only in IDLE
- iRet  in  1  return request, sampled only in IDLE
- iReturnAddr  in  DATA_WIDTH  address to save on call (PC+1)
- iTarget  in  DATA_WIDTH  call destination
- iStackPointer  in  SP_WIDTH  current stack pointer from stack
- iStackData  in  DATA_WIDTH  top-of-stack data from stack (valid while read strobe high)
- oStackWrite  out  1  push strobe to stack
- oStackRead  out  1  pop strobe to stack
- oStackData  out  DATA_WIDTH  data to push
- oBusy  out  1  sequence in progress, requests ignored
- oPCLoad  out  1  one-cycle PC load pulse
- oPCValue  out  DATA_WIDTH  value to load into PC
- oFault  out  1  sticky fault flag
- oFaultCode  out  2  first fault: 0 none, 1 overflow, 2 underflow, 3 conflict

## Operation
- FSM states: IDLE, PUSH, POP, LOAD. Outputs are Moore, decoded from registered state and latched data.
- IDLE + iCall: latch iReturnAddr into saveReg and iTarget into pcReg, then go to PUSH.
- IDLE + iRet (no iCall): go to POP.
- PUSH: oStackWrite=1, oStackData=saveReg, then go to LOAD.
- POP: oStackRead=1. At the closing edge, latch iStackData into pcReg, then go to LOAD.
- LOAD: oPCLoad=1, oPCValue=pcReg, then go to IDLE.
- oBusy=1 in PUSH, POP and LOAD. Requests arriving while oBusy=1 are dropped, not queued.
- oStackRead and oStackWrite are never high together. oStackRead always returns low for at least one cycle between pops, because the stack's read path is edge-sensitive to the strobe.
- iCall and iRet both high in IDLE: the call wins and the return is discarded.
- Reset (sync): state=IDLE; saveReg=pcReg=0.
  - Outputs after reset: oStackWrite=oStackRead=oBusy=oPCLoad=0, oStackData=oPCValue=0, oFault=0, oFaultCode=0.
  - Reset mid-sequence aborts it. No PC load is issued for the aborted request.

## Timing
- Call: request sampled at edge E0 → PUSH in cycle E0–E1 (stack writes at E1) → LOAD in cycle E1–E2 → IDLE after E2. Total latency 2 cycles to oPCLoad.
- Return: sampled at E0 → POP in cycle E0–E1 (data captured and stack pointer decremented at E1) → LOAD in cycle E1–E2.
- Earliest next request is sampled at E3, so back-to-back sequences take 3 cycles each.
- oPCLoad is high for exactly one cycle per completed sequence.

## Configuration
- Macro CALLRET_GUARD_EN.
- Defined:
  - Call in IDLE with iStackPointer==MEM_SIZE-1: fault code 1. No push, no PC load, stay in IDLE.
  - Return in IDLE with iStackPointer==0: fault code 2. No pop, no PC load, stay in IDLE.
  - Simultaneous iCall and iRet: fault code 3. The call still executes.
  - oFault sets on the first fault and holds until Reset. oFaultCode keeps the first code; later faults do not overwrite it.
- Undefined:
  - No pointer checks; calls and returns always execute, and the stack's own saturation/wrap behaviour applies.
  - oFault and oFaultCode are constant 0. Conflict resolution (call wins) is unchanged.

## Test plan
- Reset, then iCall=1 for one cycle with iReturnAddr=0x0011 and iTarget=0x0200.
  - Next cycle: oStackWrite=1 with oStackData=0x0011.
  - Cycle after: oPCLoad=1 with oPCValue=0x0200; iStackPointer goes 0→1.
- After the call above, pulse iRet → oStackRead=1 for one cycle, then oPCLoad=1 with oPCValue=0x0011; iStackPointer goes 1→0.
- Three nested calls (return addresses 0x0A, 0x0B, 0x0C) followed by three returns → oPCValue sequence 0x0C, 0x0B, 0x0A.
  - oStackRead is low between pops.
  - Each sequence takes 3 cycles.
- iCall and iRet high together in IDLE → call performed (push then load target).
  - With CALLRET_GUARD_EN: oFault=1, oFaultCode=3.
- With CALLRET_GUARD_EN, iRet at iStackPointer=0 → no strobes, no oPCLoad, oFault=1, oFaultCode=2.
  - A subsequent overflow leaves oFaultCode=2.
- Assert Reset during the PUSH cycle of a call → next cycle: state IDLE, oBusy=0, oPCLoad never pulses, all outputs 0.
